// File: rtl/adc_pkg.sv
// Shared DRP widths, default channel addresses and sequencer states
// for the ADC stand-in responder.
package adc_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int SAMP_W = 12;

  localparam logic [ADDR_W-1:0] CH_A_DEF = 7'h13;
  localparam logic [ADDR_W-1:0] CH_B_DEF = 7'h1b;

  typedef enum logic {
    CONV_A,
    CONV_B
  } seq_t;

endpackage

// File: rtl/drp_read_port.sv
// DRP read responder: snapshot on accept, fixed-latency drdy,
// sticky error on overlapping den.
module drp_read_port
  import adc_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              den,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] do_data,
  output logic              drdy,
  output logic              err
);

  logic              pend;
  logic [1:0]        lat;
  logic [DATA_W-1:0] snap;
  logic              accept;
  logic              fire;

  // pend stays set through the edge that raises drdy
  assign accept = den & ~pend;
  assign fire   = pend & (lat == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      lat     <= 2'd0;
      snap    <= '0;
      drdy    <= 1'b0;
      do_data <= '0;
      err     <= 1'b0;
    end else begin
      drdy    <= fire;
      do_data <= fire ? snap : '0;
      if (den && pend)
        err <= 1'b1;
      if (accept) begin
        pend <= 1'b1;
        lat  <= 2'(READ_LATENCY - 1);
        snap <= rd_data;
      end else if (pend) begin
        if (lat == 2'd0)
          pend <= 1'b0;
        else
          lat <= lat - 2'd1;
      end
    end
  end

endmodule

// File: rtl/adc_drp_responder.sv
// Two-channel conversion sequencer with per-channel result
// registers, answered over a DRP read port.
module adc_drp_responder
  import adc_pkg::*;
#(
  parameter int                CONV_CYCLES  = 26,
  parameter int                READ_LATENCY = 2,
  parameter logic [ADDR_W-1:0] CH_A_ADDR    = CH_A_DEF,
  parameter logic [ADDR_W-1:0] CH_B_ADDR    = CH_B_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SAMP_W-1:0] sample_a,
  input  logic [SAMP_W-1:0] sample_b,
  input  logic              den,
  input  logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] do_data,
  output logic              drdy,
  output logic              eoc,
  output logic [ADDR_W-1:0] channel,
  output logic              err
);

  localparam int CW = $clog2(CONV_CYCLES);

  seq_t              state_q;
  seq_t              state_d;
  logic [CW-1:0]     cnt;
  logic              tc;
  logic              ld_a;
  logic              ld_b;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;
  logic [DATA_W-1:0] rd_val;

  assign tc = (cnt == CW'(CONV_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= CONV_A;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CONV_A: if (tc) state_d = CONV_B;
      CONV_B: if (tc) state_d = CONV_A;
      default: state_d = CONV_A;
    endcase
  end

  always_comb begin
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    cur_addr = CH_A_ADDR;
    unique case (state_q)
      CONV_A: ld_a = tc;
      CONV_B: begin
        ld_b     = tc;
        cur_addr = CH_B_ADDR;
      end
      default: ld_a = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      eoc     <= 1'b0;
      channel <= '0;
      res_a   <= '0;
      res_b   <= '0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      eoc <= tc;
      if (tc)
        channel <= cur_addr;
      if (ld_a)
        res_a <= {sample_a, 4'h0};
      if (ld_b)
        res_b <= {sample_b, 4'h0};
    end
  end

  // registered results are read here, so a same-edge load is not seen
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      (daddr == CH_A_ADDR): rd_val = res_a;
      (daddr == CH_B_ADDR): rd_val = res_b;
      default:              rd_val = '0;
    endcase
  end

  drp_read_port #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd (
    .clk    (clk),
    .rst_n  (rst_n),
    .den    (den),
    .rd_data(rd_val),
    .do_data(do_data),
    .drdy   (drdy),
    .err    (err)
  );

endmodule

// File: tb/tb_adc_drp_responder.sv
// Scoreboard bench for adc_drp_responder: conversions, reads,
// collisions, overlap error and mid-read reset.
module tb_adc_drp_responder;

  localparam int CC  = 26;
  localparam int LAT = 2;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample_a = 12'hABC;
  logic [11:0] sample_b = 12'h123;
  logic        den = 1'b0;
  logic [6:0]  daddr = 7'h00;
  logic [15:0] do_data;
  logic        drdy;
  logic        eoc;
  logic [6:0]  channel;
  logic        err;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  err_from = 1 << 30;
  rd_t q[$];

  adc_drp_responder #(
    .CONV_CYCLES (CC),
    .READ_LATENCY(LAT),
    .CH_A_ADDR   (7'h13),
    .CH_B_ADDR   (7'h1b)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sample_a(sample_a),
    .sample_b(sample_b),
    .den     (den),
    .daddr   (daddr),
    .do_data (do_data),
    .drdy    (drdy),
    .eoc     (eoc),
    .channel (channel),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d",
               tag, got, exp, cyc);
    end
  endtask

  // value the read port should snapshot at accepting edge k
  function automatic logic [15:0] exp_rd(input logic [6:0] a,
                                         input int k);
    logic [15:0] ra, rb;
    ra = (k >= CC + 1)     ? 16'hABC0 : 16'h0000;
    rb = (k >= 2 * CC + 1) ? 16'h1230 : 16'h0000;
    if (a == 7'h13)      return ra;
    else if (a == 7'h1b) return rb;
    else                 return 16'h0000;
  endfunction

  always @(negedge clk) begin
    int          n;
    logic        e_eoc;
    logic [6:0]  e_ch;
    n     = cyc / CC;
    e_eoc = (cyc > 0) && (cyc % CC == 0);
    e_ch  = (n == 0) ? 7'h00 : ((n % 2 == 1) ? 7'h13 : 7'h1b);
    chk("eoc", 32'(eoc), 32'(e_eoc));
    chk("channel", 32'(channel), 32'(e_ch));
    chk("err", 32'(err), 32'(cyc >= err_from));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("drdy", 32'(drdy), 32'd1);
      chk("rdata", 32'(do_data), 32'(q[0].data));
      void'(q.pop_front());
    end else begin
      if (q.size() > 0 && q[0].due < cyc)
        void'(q.pop_front());
      chk("drdy_idle", 32'(drdy), 32'd0);
      chk("do_idle", 32'(do_data), 32'd0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_to(input int n);
    int g = 0;
    while (cyc < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) chk("timeout", 32'(cyc), 32'(n));
  endtask

  task automatic issue(input logic [6:0] a, input bit acc);
    rd_t r;
    den   = 1'b1;
    daddr = a;
    if (acc) begin
      r.due  = cyc + 1 + LAT;
      r.data = exp_rd(a, cyc + 1);
      q.push_back(r);
    end
  endtask

  task automatic rd(input logic [6:0] a, input int k);
    wait_to(k - 1);
    issue(a, 1'b1);
    step();
    den = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    #1 rst_n = 1'b1;

    rd(7'h13, CC);
    rd(7'h13, 30);
    rd(7'h1b, 56);
    rd(7'h00, 60);

    wait_to(70);
    issue(7'h13, 1'b1);
    step();
    issue(7'h1b, 1'b0);
    err_from = 72;
    step();
    den = 1'b0;

    rd(7'h1b, 74);
    rd(7'h13, 77);

    rd(7'h13, 90);
    #1 rst_n = 1'b0;
    q.delete();
    err_from = 1 << 30;
    repeat (3) step();
    #1 rst_n = 1'b1;

    wait_to(CC + 4);
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
